multicycle_controller: RTL and testbench
========================================

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have parameter: MEM_TIMEOUT, default 16, max consecutive wait cycles on a memory request before fault; 0 disables the timeout.
REQ-002 SHALL have port: clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports: op_i  input  7  opcode; funct3_i  input  3; funct7_i  input  1  (instr bit 30); Zero_i  input  1  ALU zero flag.
REQ-005 SHALL have port: mem_ready_i  input  1  memory completes the current request this cycle.
REQ-006 SHALL have ports: PCWrite_o, IRWrite_o, RegWrite_o, MemWrite_o, MemRead_o  output  1 each  datapath strobes.
REQ-007 SHALL have ports: AdrSrc_o  output  1  (0 PC, 1 ALUOut); ResultSrc_o  output  2  (00 ALUOut, 01 read data, 10 ALU result).
REQ-008 SHALL have ports: ALUSrcA_o  output  2  (00 PC, 01 OldPC, 10 rs1); ALUSrcB_o  output  2  (00 rs2, 01 imm, 10 const 4).
REQ-009 SHALL have ports: ALUControl_o  output  3  (000 add, 001 sub, 010 slt, 011 or, 111 and); ImmSrc_o  output  3  (000 I, 001 B, 010 S, 100 J).
REQ-010 SHALL have ports: state_o  output  4  current state code; err_o  output  1  sticky fault flag.

Function
REQ-011 SHALL implement a Moore FSM, states: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, ERROR; outputs not listed for a state SHALL be 0.
REQ-012 FETCH: MemRead=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ResultSrc=10, add; IRWrite and PCWrite SHALL pulse only in the cycle mem_ready_i=1, then -> DECODE; otherwise stay.
REQ-013 DECODE: ALUSrcA=01, ALUSrcB=01, add; ImmSrc from op_i; next: load 0000011 or store 0100011 -> MEMADR, 0110011 -> EXECR, 0010011 -> EXECI, 1100011 -> BRANCH, 1101111 -> JAL, any other -> ERROR.
REQ-014 MEMADR: ALUSrcA=10, ALUSrcB=01, add; -> MEMREAD for load, MEMWRITE for store.
REQ-015 MEMREAD: AdrSrc=1, MemRead=1 held until mem_ready_i=1, then -> MEMWB; MEMWB: ResultSrc=01, RegWrite=1, -> FETCH.
REQ-016 MEMWRITE: AdrSrc=1, MemWrite=1 held until mem_ready_i=1, then -> FETCH.
REQ-017 EXECR: ALUSrcA=10, ALUSrcB=00; EXECI: ALUSrcA=10, ALUSrcB=01; both -> ALUWB; ALUControl from funct3: 000 add (sub if EXECR and funct7_i=1), 010 slt, 110 or, 111 and, other funct3 -> add.
REQ-018 ALUWB: ResultSrc=00, RegWrite=1, -> FETCH.
REQ-019 BRANCH: ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00; PCWrite=Zero_i for funct3 000, ~Zero_i for 001, 0 otherwise; -> FETCH.
REQ-020 JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1; -> ALUWB.
REQ-021 A wait counter SHALL count consecutive cycles with mem_ready_i=0 in FETCH/MEMREAD/MEMWRITE, clear on mem_ready_i=1 or state exit; reaching MEM_TIMEOUT (non-zero) SHALL -> ERROR next cycle.
REQ-022 ERROR: all strobes 0, err_o=1; SHALL remain until rst.
REQ-023 Latencies with zero-wait memory: R/I 4 cycles, load 5, store 4, branch 3, JAL 4.

Reset
REQ-024 rst=1 SHALL immediately force state FETCH, wait counter 0, err_o 0, all strobes per FETCH with mem_ready_i gating, independent of clk.
REQ-025 Reset mid-transfer SHALL abandon the request; first post-reset cycle SHALL be FETCH.

Configuration
REQ-026 Macro MCC_PERF_CNT_EN defined: outputs cycle_o[31:0] (+1 every clock not in reset) and retired_o[31:0] (+1 on each transition into FETCH from MEMWB, MEMWRITE, ALUWB, BRANCH), both wrap at 2^32, cleared by rst.
REQ-027 Macro undefined: cycle_o and retired_o SHALL exist and be tied to 0; no counter logic.

Verification
REQ-028 add (0110011, f3 000, f7 0), ready=1 -> FETCH, DECODE, EXECR(ALUControl 000), ALUWB(RegWrite 1), FETCH.
REQ-029 lw with ready low 3 cycles in MEMREAD -> MemRead held 4 cycles, then MEMWB with ResultSrc=01, RegWrite=1.
REQ-030 bne, Zero_i=0 -> PCWrite=1 in BRANCH; same with Zero_i=1 -> PCWrite=0.
REQ-031 op_i=1111111 in DECODE -> ERROR, err_o=1 held 10 cycles; rst -> FETCH, err_o=0.
REQ-032 MEM_TIMEOUT=4, ready stuck 0 in FETCH -> ERROR after 4 wait cycles.
REQ-033 MCC_PERF_CNT_EN, three add instructions -> retired_o=3, cycle_o=12.

Source files
------------

// File: rtl/multicycle_controller.sv
// multicycle_controller: multicycle RISC-V control FSM with memory-wait timeout.
// Define MCC_PERF_CNT_EN to enable the cycle_o/retired_o performance counters.
module multicycle_controller #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  op_i,
    input  logic [2:0]  funct3_i,
    input  logic        funct7_i,
    input  logic        Zero_i,
    input  logic        mem_ready_i,
    output logic        PCWrite_o,
    output logic        IRWrite_o,
    output logic        RegWrite_o,
    output logic        MemWrite_o,
    output logic        MemRead_o,
    output logic        AdrSrc_o,
    output logic [1:0]  ResultSrc_o,
    output logic [1:0]  ALUSrcA_o,
    output logic [1:0]  ALUSrcB_o,
    output logic [2:0]  ALUControl_o,
    output logic [2:0]  ImmSrc_o,
    output logic [3:0]  state_o,
    output logic        err_o,
    output logic [31:0] cycle_o,
    output logic [31:0] retired_o
);
    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9,
        JAL      = 4'd10,
        ERROR    = 4'd11
    } state_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST_WAIT = CW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    state_t        state, state_d;
    logic [CW-1:0] wait_cnt, wait_cnt_d;
    logic          mem_state, timeout;
    logic [2:0]    alu_f;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= FETCH;
            wait_cnt <= '0;
        end else begin
            state    <= state_d;
            wait_cnt <= wait_cnt_d;
        end
    end

    // The cycle that would be the MEM_TIMEOUT-th consecutive wait diverts to ERROR
    assign mem_state  = (state == FETCH) || (state == MEMREAD) || (state == MEMWRITE);
    assign timeout    = (MEM_TIMEOUT != 0) && mem_state && !mem_ready_i && (wait_cnt == LAST_WAIT);
    assign wait_cnt_d = (mem_state && !mem_ready_i && !timeout) ? wait_cnt + 1'b1 : '0;

    always_comb begin
        unique case (funct3_i)
            3'b000:  alu_f = (state == EXECR && funct7_i) ? 3'b001 : 3'b000;
            3'b010:  alu_f = 3'b010;
            3'b110:  alu_f = 3'b011;
            3'b111:  alu_f = 3'b111;
            default: alu_f = 3'b000;
        endcase
    end

    always_comb begin
        state_d      = state;
        PCWrite_o    = 1'b0;
        IRWrite_o    = 1'b0;
        RegWrite_o   = 1'b0;
        MemWrite_o   = 1'b0;
        MemRead_o    = 1'b0;
        AdrSrc_o     = 1'b0;
        ResultSrc_o  = 2'b00;
        ALUSrcA_o    = 2'b00;
        ALUSrcB_o    = 2'b00;
        ALUControl_o = 3'b000;
        ImmSrc_o     = 3'b000;
        err_o        = 1'b0;
        case (state)
            FETCH: begin
                MemRead_o   = 1'b1;
                ALUSrcB_o   = 2'b10;
                ResultSrc_o = 2'b10;
                IRWrite_o   = mem_ready_i;
                PCWrite_o   = mem_ready_i;
                if (timeout) state_d = ERROR;
                else if (mem_ready_i) state_d = DECODE;
            end
            DECODE: begin
                ALUSrcA_o = 2'b01;
                ALUSrcB_o = 2'b01;
                case (op_i)
                    OP_LOAD:  state_d = MEMADR;
                    OP_STORE: begin state_d = MEMADR; ImmSrc_o = 3'b010; end
                    OP_R:     state_d = EXECR;
                    OP_I:     state_d = EXECI;
                    OP_B:     begin state_d = BRANCH; ImmSrc_o = 3'b001; end
                    OP_JAL:   begin state_d = JAL; ImmSrc_o = 3'b100; end
                    default:  state_d = ERROR;
                endcase
            end
            MEMADR: begin
                ALUSrcA_o = 2'b10;
                ALUSrcB_o = 2'b01;
                state_d   = (op_i == OP_STORE) ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                AdrSrc_o  = 1'b1;
                MemRead_o = 1'b1;
                if (timeout) state_d = ERROR;
                else if (mem_ready_i) state_d = MEMWB;
            end
            MEMWB: begin
                ResultSrc_o = 2'b01;
                RegWrite_o  = 1'b1;
                state_d     = FETCH;
            end
            MEMWRITE: begin
                AdrSrc_o   = 1'b1;
                MemWrite_o = 1'b1;
                if (timeout) state_d = ERROR;
                else if (mem_ready_i) state_d = FETCH;
            end
            EXECR: begin
                ALUSrcA_o    = 2'b10;
                ALUControl_o = alu_f;
                state_d      = ALUWB;
            end
            EXECI: begin
                ALUSrcA_o    = 2'b10;
                ALUSrcB_o    = 2'b01;
                ALUControl_o = alu_f;
                state_d      = ALUWB;
            end
            ALUWB: begin
                RegWrite_o = 1'b1;
                state_d    = FETCH;
            end
            BRANCH: begin
                ALUSrcA_o    = 2'b10;
                ALUControl_o = 3'b001;
                PCWrite_o    = (funct3_i == 3'b000) ? Zero_i :
                               (funct3_i == 3'b001) ? ~Zero_i : 1'b0;
                state_d      = FETCH;
            end
            JAL: begin
                ALUSrcA_o = 2'b01;
                ALUSrcB_o = 2'b10;
                PCWrite_o = 1'b1;
                state_d   = ALUWB;
            end
            default: begin
                err_o   = 1'b1;
                state_d = ERROR;
            end
        endcase
    end

    assign state_o = state;

`ifdef MCC_PERF_CNT_EN
    logic [31:0] cycle_q, retired_q;
    logic        retire;

    assign retire = (state_d == FETCH) &&
                    ((state == MEMWB) || (state == MEMWRITE) ||
                     (state == ALUWB) || (state == BRANCH));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_q   <= '0;
            retired_q <= '0;
        end else begin
            cycle_q <= cycle_q + 32'd1;
            if (retire) retired_q <= retired_q + 32'd1;
        end
    end

    assign cycle_o   = cycle_q;
    assign retired_o = retired_q;
`else
    assign cycle_o   = '0;
    assign retired_o = '0;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: directed and random stimulus against an
// instruction-plan model of the multicycle controller.
module tb_multicycle_controller;
    localparam int TMO = 4;

    localparam int S_FETCH = 0, S_DECODE = 1, S_MEMADR = 2, S_MEMREAD = 3;
    localparam int S_MEMWB = 4, S_MEMWRITE = 5, S_EXECR = 6, S_EXECI = 7;
    localparam int S_ALUWB = 8, S_BRANCH = 9, S_JAL = 10, S_ERROR = 11;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  op_i;
    logic [2:0]  funct3_i;
    logic        funct7_i, Zero_i, mem_ready_i;
    logic        PCWrite_o, IRWrite_o, RegWrite_o, MemWrite_o, MemRead_o, AdrSrc_o;
    logic [1:0]  ResultSrc_o, ALUSrcA_o, ALUSrcB_o;
    logic [2:0]  ALUControl_o, ImmSrc_o;
    logic [3:0]  state_o;
    logic        err_o;
    logic [31:0] cycle_o, retired_o;

    multicycle_controller #(.MEM_TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .op_i(op_i), .funct3_i(funct3_i),
        .funct7_i(funct7_i), .Zero_i(Zero_i), .mem_ready_i(mem_ready_i),
        .PCWrite_o(PCWrite_o), .IRWrite_o(IRWrite_o), .RegWrite_o(RegWrite_o),
        .MemWrite_o(MemWrite_o), .MemRead_o(MemRead_o), .AdrSrc_o(AdrSrc_o),
        .ResultSrc_o(ResultSrc_o), .ALUSrcA_o(ALUSrcA_o), .ALUSrcB_o(ALUSrcB_o),
        .ALUControl_o(ALUControl_o), .ImmSrc_o(ImmSrc_o), .state_o(state_o),
        .err_o(err_o), .cycle_o(cycle_o), .retired_o(retired_o)
    );

    always #5 clk = ~clk;

    int     errors = 0;
    int     checks = 0;
    int     m_state = S_FETCH;
    int     m_wait = 0;
    int     plan[$];
    longint m_cyc = 0;
    longint m_ret = 0;

    logic [3:0]  obs_state;
    logic        obs_pcw, obs_mr, obs_err;
    logic [31:0] obs_cyc, obs_ret;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic logic [2:0] alu_op(input logic [2:0] f3, input logic sub);
        case (f3)
            3'b000:  return sub ? 3'b001 : 3'b000;
            3'b010:  return 3'b010;
            3'b110:  return 3'b011;
            3'b111:  return 3'b111;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [22:0] expect_out(input int s, input logic [6:0] op,
        input logic [2:0] f3, input logic f7, input logic z, input logic rdy);
        logic pcw = 0, irw = 0, rw = 0, mw = 0, mr = 0, adr = 0, err = 0;
        logic [1:0] rs = 0, sa = 0, sb = 0;
        logic [2:0] alu = 0, imm = 0;
        case (s)
            S_FETCH:    begin mr = 1; sb = 2; rs = 2; irw = rdy; pcw = rdy; end
            S_DECODE: begin
                sa = 1; sb = 1;
                if (op == 7'b1100011) imm = 3'b001;
                else if (op == 7'b0100011) imm = 3'b010;
                else if (op == 7'b1101111) imm = 3'b100;
            end
            S_MEMADR:   begin sa = 2; sb = 1; end
            S_MEMREAD:  begin adr = 1; mr = 1; end
            S_MEMWB:    begin rs = 1; rw = 1; end
            S_MEMWRITE: begin adr = 1; mw = 1; end
            S_EXECR:    begin sa = 2; alu = alu_op(f3, f7); end
            S_EXECI:    begin sa = 2; sb = 1; alu = alu_op(f3, 1'b0); end
            S_ALUWB:    rw = 1;
            S_BRANCH: begin
                sa = 2; alu = 3'b001;
                pcw = (f3 == 3'b000) ? z : (f3 == 3'b001) ? !z : 1'b0;
            end
            S_JAL:      begin sa = 1; sb = 2; pcw = 1; end
            default:    err = 1;
        endcase
        return {pcw, irw, rw, mw, mr, adr, rs, sa, sb, alu, imm, 4'(s), err};
    endfunction

    // Model: each decoded instruction becomes a queue of remaining steps
    task automatic model_advance(input logic rdy, input logic [6:0] op);
        int nxt;
        nxt = m_state;
        if (m_state == S_FETCH || m_state == S_MEMREAD || m_state == S_MEMWRITE) begin
            if (rdy) begin
                m_wait = 0;
                if (m_state == S_FETCH) nxt = S_DECODE;
                else if (plan.size() > 0) nxt = plan.pop_front();
                else nxt = S_FETCH;
            end else begin
                m_wait++;
                if (m_wait == TMO) begin
                    nxt = S_ERROR;
                    m_wait = 0;
                end
            end
        end else if (m_state == S_DECODE) begin
            plan.delete();
            case (op)
                7'b0000011: plan = '{S_MEMADR, S_MEMREAD, S_MEMWB};
                7'b0100011: plan = '{S_MEMADR, S_MEMWRITE};
                7'b0110011: plan = '{S_EXECR, S_ALUWB};
                7'b0010011: plan = '{S_EXECI, S_ALUWB};
                7'b1100011: plan = '{S_BRANCH};
                7'b1101111: plan = '{S_JAL, S_ALUWB};
                default:    plan = '{S_ERROR};
            endcase
            nxt = plan.pop_front();
        end else if (m_state != S_ERROR) begin
            if (plan.size() > 0) nxt = plan.pop_front();
            else nxt = S_FETCH;
        end
        if (nxt == S_FETCH && (m_state == S_MEMWB || m_state == S_MEMWRITE ||
                               m_state == S_ALUWB || m_state == S_BRANCH))
            m_ret++;
        m_cyc++;
        m_state = nxt;
    endtask

    task automatic step(input logic r, input logic rdy, input logic [6:0] op,
                        input logic [2:0] f3, input logic f7, input logic z);
        logic [22:0] got;
        rst = r; mem_ready_i = rdy; op_i = op;
        funct3_i = f3; funct7_i = f7; Zero_i = z;
        if (r) begin
            m_state = S_FETCH; m_wait = 0; plan.delete();
            m_cyc = 0; m_ret = 0;
        end
        @(negedge clk);
        got = {PCWrite_o, IRWrite_o, RegWrite_o, MemWrite_o, MemRead_o, AdrSrc_o,
               ResultSrc_o, ALUSrcA_o, ALUSrcB_o, ALUControl_o, ImmSrc_o, state_o, err_o};
        check("outputs", 64'(got), 64'(expect_out(m_state, op, f3, f7, z, rdy)));
`ifdef MCC_PERF_CNT_EN
        check("perf", {cycle_o, retired_o}, {m_cyc[31:0], m_ret[31:0]});
`else
        check("perf", {cycle_o, retired_o}, 64'd0);
`endif
        obs_state = state_o; obs_pcw = PCWrite_o; obs_mr = MemRead_o;
        obs_err = err_o; obs_cyc = cycle_o; obs_ret = retired_o;
        if (!r) model_advance(rdy, op);
        @(posedge clk);
        #1;
    endtask

    localparam logic [6:0] ADD = 7'b0110011;

    initial begin
        logic [19:0] seq;
        int n;
        logic [6:0] cop;
        logic [2:0] cf3;
        logic cf7, r;
        int err_cycles;

        step(1, 1, ADD, 3'b000, 0, 0);
        check("reset_state", 64'(obs_state), 64'd0);

        seq = '0;
        for (int i = 0; i < 5; i++) begin
            step(0, 1, ADD, 3'b000, 0, 0);
            seq = {seq[15:0], obs_state};
        end
        check("add_sequence", 64'(seq), 64'h01680);

        step(1, 0, ADD, 3'b000, 0, 0);
        check("rst_async_state", 64'(obs_state), 64'd0);

        n = 0;
        for (int i = 0; i < 8; i++) begin
            step(0, (i < 3 || i > 5), 7'b0000011, 3'b010, 0, 0);
            if (obs_state == 4'd3 && obs_mr) n++;
        end
        check("lw_memread_cycles", 64'(n), 64'd4);
        check("lw_memwb", 64'(obs_state), 64'd4);

        for (int zz = 0; zz < 2; zz++) begin
            step(1, 1, 7'b1100011, 3'b001, 0, 1'(zz));
            for (int i = 0; i < 3; i++) step(0, 1, 7'b1100011, 3'b001, 0, 1'(zz));
            check("bne_state", 64'(obs_state), 64'd9);
            check("bne_pcwrite", 64'(obs_pcw), (zz == 0) ? 64'd1 : 64'd0);
        end

        step(1, 1, 7'h7f, 3'b000, 0, 0);
        step(0, 1, 7'h7f, 3'b000, 0, 0);
        step(0, 1, 7'h7f, 3'b000, 0, 0);
        n = 0;
        for (int i = 0; i < 10; i++) begin
            step(0, 1, 7'h7f, 3'b000, 0, 0);
            if (obs_err && obs_state == 4'd11) n++;
        end
        check("illegal_err_held", 64'(n), 64'd10);
        step(1, 1, ADD, 3'b000, 0, 0);
        check("err_cleared", 64'({obs_state, obs_err}), 64'd0);

        n = 0;
        for (int i = 0; i < 10; i++) begin
            step(0, 0, ADD, 3'b000, 0, 0);
            if (obs_state == 4'd11) break;
            n++;
        end
        check("timeout_waits", 64'(n), 64'd4);
        check("timeout_error", 64'(obs_state), 64'd11);

        step(1, 1, ADD, 3'b000, 0, 0);
        for (int i = 0; i < 13; i++) step(0, 1, ADD, 3'b000, 0, 0);
`ifdef MCC_PERF_CNT_EN
        check("perf_three_adds", {obs_cyc, obs_ret}, {32'd12, 32'd3});
`else
        check("perf_tied_zero", {obs_cyc, obs_ret}, 64'd0);
`endif

        cop = ADD; cf3 = 0; cf7 = 0; err_cycles = 0;
        for (int i = 0; i < 3000; i++) begin
            if (m_state == S_FETCH) begin
                case ($urandom_range(0, 7))
                    0: cop = 7'b0000011;
                    1: cop = 7'b0100011;
                    2: cop = 7'b0110011;
                    3: cop = 7'b0010011;
                    4: cop = 7'b1100011;
                    5: cop = 7'b1101111;
                    default: cop = 7'($urandom);
                endcase
                cf3 = 3'($urandom);
                cf7 = 1'($urandom);
            end
            err_cycles = (m_state == S_ERROR) ? err_cycles + 1 : 0;
            r = ($urandom_range(0, 99) < 2) || (err_cycles > 6);
            step(r, $urandom_range(0, 9) < 7, cop, cf3, cf7, 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
